// File: rtl/core_mem_pkg.sv
// core_mem_pkg: response-owner encoding and write-strobe constants shared by the memory port logic
package core_mem_pkg;
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_e;
  localparam logic [3:0] WSTRB_READ = 4'b0000;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// mem_port_arbiter_pick: one-hot grant chooser; in inst_req/data_req/at_limit, out grant_inst/grant_data
module mem_port_arbiter_pick (
  input  logic inst_req,
  input  logic data_req,
  input  logic at_limit,
  output logic grant_inst,
  output logic grant_data
);
  always_comb begin
    grant_data = data_req && !(inst_req && at_limit);
    grant_inst = inst_req && !grant_data;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM between fetch (inst_*) and load/store (data_*) ports with streak-limited data priority
module mem_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);
  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  if (DATA_STREAK_MAX < 1) begin : g_bad_streak
    $error("mem_port_arbiter: DATA_STREAK_MAX must be at least 1");
  end
  logic [SW-1:0] streak;
  logic          at_limit;
  logic          pick_inst;
  logic          pick_data;
  resp_e         owner;
  resp_e         owner_nx;
  assign at_limit = streak == SW'(DATA_STREAK_MAX);
  mem_port_arbiter_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .at_limit   (at_limit),
    .grant_inst (pick_inst),
    .grant_data (pick_data)
  );
  always_comb begin
    inst_addr_ok = pick_inst && !reset;
    data_addr_ok = pick_data && !reset;
    sram_en      = inst_addr_ok || data_addr_ok;
    sram_we      = data_addr_ok ? data_wstrb : WSTRB_READ;
    sram_addr    = data_addr_ok ? data_addr : inst_addr;
    sram_wdata   = data_addr_ok ? data_wdata : '0;
    inst_data_ok = owner == RESP_INST;
    data_data_ok = owner == RESP_DATA;
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = data_data_ok ? sram_rdata : '0;
  end
  always_comb begin
    owner_nx = inst_addr_ok ? RESP_INST : data_addr_ok ? RESP_DATA : RESP_NONE;
  end
  always_ff @(posedge clk) begin
    owner <= reset ? RESP_NONE : owner_nx;
  end
  // Streak only counts data grants that actually made fetch wait.
  always_ff @(posedge clk) begin
    if (reset || !inst_req || inst_addr_ok) streak <= '0;
    else if (data_addr_ok && !at_limit) streak <= streak + 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          chk;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  logic [31:0] mem [logic [29:0]];

  mem_port_arbiter #(.DATA_STREAK_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    logic [31:0] old;
    if (sram_en === 1'b1) begin
      old = mem.exists(sram_addr[31:2]) ? mem[sram_addr[31:2]] : 32'h0;
      sram_rdata <= old;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) old[8*b +: 8] = sram_wdata[8*b +: 8];
      mem[sram_addr[31:2]] = old;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   ei;
    bit   ed;
    if (mon_on) begin
      while (iq.size() > 0 && iq[0].due < cyc) void'(iq.pop_front());
      while (dq.size() > 0 && dq[0].due < cyc) void'(dq.pop_front());
      ei = iq.size() > 0 && iq[0].due == cyc;
      ed = dq.size() > 0 && dq[0].due == cyc;
      total++;
      if (inst_data_ok !== ei) begin
        bad++;
        $display("FAIL inst_data_ok cyc=%0d got=%b want=%b", cyc, inst_data_ok, ei);
      end
      total++;
      if (data_data_ok !== ed) begin
        bad++;
        $display("FAIL data_data_ok cyc=%0d got=%b want=%b", cyc, data_data_ok, ed);
      end
      if (ei) begin
        e = iq.pop_front();
        total++;
        if (inst_rdata !== e.data) begin
          bad++;
          $display("FAIL inst_rdata cyc=%0d got=%h want=%h", cyc, inst_rdata, e.data);
        end
      end else begin
        total++;
        if (inst_rdata !== 32'h0) begin
          bad++;
          $display("FAIL inst_rdata_idle cyc=%0d got=%h want=0", cyc, inst_rdata);
        end
      end
      if (ed) begin
        e = dq.pop_front();
        if (e.chk) begin
          total++;
          if (data_rdata !== e.data) begin
            bad++;
            $display("FAIL data_rdata cyc=%0d got=%h want=%h", cyc, data_rdata, e.data);
          end
        end
      end else begin
        total++;
        if (data_rdata !== 32'h0) begin
          bad++;
          $display("FAIL data_rdata_idle cyc=%0d got=%h want=0", cyc, data_rdata);
        end
      end
    end
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] want, input string nm);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input logic [3:0] ws,
                      input logic [31:0] da, input logic [31:0] wd, input bit ei, input bit ed,
                      input logic [31:0] ri, input logic [31:0] rd, input bit cd, input string nm);
    inst_req = ir;
    inst_addr = ia;
    data_req = dr;
    data_wstrb = ws;
    data_addr = da;
    data_wdata = wd;
    @(negedge clk);
    chk({31'h0, inst_addr_ok}, {31'h0, ei}, {nm, " inst_addr_ok"});
    chk({31'h0, data_addr_ok}, {31'h0, ed}, {nm, " data_addr_ok"});
    chk({31'h0, sram_en}, {31'h0, ei | ed}, {nm, " sram_en"});
    chk({28'h0, sram_we}, {28'h0, ed ? ws : 4'h0}, {nm, " sram_we"});
    if (ei || ed) chk(sram_addr, ed ? da : ia, {nm, " sram_addr"});
    if (ed && ws != 4'h0) chk(sram_wdata, wd, {nm, " sram_wdata"});
    if (ei) iq.push_back('{cyc + 1, ri, 1'b1});
    if (ed) dq.push_back('{cyc + 1, rd, cd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, nm);
  endtask

  task automatic contend(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      bit gi;
      gi = (i % 5) == 4;
      step(1, 32'h1c000000, 1, 4'h0, 32'h100, 0, gi, !gi, 32'h12345678, 32'hdeadbeef, 1, nm);
    end
  endtask

  initial begin
    mem[30'h07000000] = 32'h12345678;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    step(1, 32'h1c000000, 1, 4'hf, 32'h100, 32'h1, 0, 0, 0, 0, 0, "reset_gate");
    reset = 1'b0;
    idle("post_reset");
    step(1, 32'h1c000000, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, 0, "fetch");
    step(0, 0, 1, 4'hf, 32'h100, 32'hdeadbeef, 0, 1, 0, 0, 0, "store");
    step(0, 0, 1, 4'h0, 32'h100, 0, 0, 1, 0, 32'hdeadbeef, 1, "load");
    step(0, 0, 1, 4'hf, 32'h200, 32'h11223344, 0, 1, 0, 0, 0, "store_word");
    step(0, 0, 1, 4'b0010, 32'h200, 32'h0000ab00, 0, 1, 0, 0, 0, "store_byte");
    step(0, 0, 1, 4'h0, 32'h200, 0, 0, 1, 0, 32'h1122ab44, 1, "load_byte");
    contend(10, "contend");
    contend(2, "pre_reset");
    reset = 1'b1;
    step(1, 32'h1c000000, 1, 4'h0, 32'h100, 0, 0, 0, 0, 0, 0, "reset_mid");
    reset = 1'b0;
    idle("after_reset");
    contend(10, "contend_restart");
    for (int i = 0; i < 10; i++) idle("idle");
    chk(iq.size(), 0, "inst_queue_drained");
    chk(dq.size(), 0, "data_queue_drained");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single synchronous single-port SRAM between the CPU instruction-fetch requester and the data (load/store) requester. It sits between the core and the unified SRAM, replacing the separate inst/data SRAM ports. Each requester uses an addr_ok/data_ok handshake with a fixed one-cycle response. A streak limiter stops load/store traffic from starving fetch.

## Interface
- DATA_STREAK_MAX, default 4: the maximum number of consecutive data grants while inst is requesting. After that many, inst receives one grant.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid (one-cycle pulse)
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request
- data_wstrb  in  4  byte write strobes; 4'b0000 means a read
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load data valid, or store complete (one-cycle pulse)
- data_rdata  out  32  load data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid in the cycle after sram_en

## Operation
- Grant decision is combinational each cycle, from inst_req, data_req, and the streak counter.
  - Only one requester active: that requester is granted.
  - Both active and streak < DATA_STREAK_MAX: data is granted.
  - Both active and streak == DATA_STREAK_MAX: inst is granted.
- Granted requester sees addr_ok = 1 in the same cycle.
- SRAM drive on a grant:
  - sram_en = 1.
  - sram_addr/sram_wdata/sram_we come from the granted requester.
  - sram_we = data_wstrb on a data grant, and 4'b0000 on an inst grant.
- No grant: sram_en = 0, sram_we = 0.
- Streak counter (width clog2(DATA_STREAK_MAX+1)):
  - Increments on a data grant while inst_req = 1.
  - Clears to 0 on any inst grant, or on any cycle with inst_req = 0.
  - Saturates at DATA_STREAK_MAX.
- Response owner register, states and transitions:
  - States: RESP_NONE, RESP_INST, RESP_DATA.
  - Next state is the owner of this cycle's grant, or RESP_NONE when nothing is granted.
  - RESP_INST → inst_data_ok = 1, inst_rdata = sram_rdata.
  - RESP_DATA → data_data_ok = 1, data_rdata = sram_rdata. For a store, the rdata value is don't-care.
- Back-to-back grants are allowed every cycle, so throughput is one access per cycle.
- A grant and the previous grant's response overlap in the same cycle.
- Requesters must accept data_ok unconditionally. There is no response back-pressure.
- Requesters must hold req/addr/wdata/wstrb stable until addr_ok. The arbiter does not latch request fields.
- rdata outputs are 0 whenever the matching data_ok is 0.

## Timing
- Reset values, driven in the cycle after reset is sampled high:
  - owner = RESP_NONE, streak = 0.
  - inst_data_ok = data_data_ok = 0, rdata outputs = 0.
- While reset is high, addr_ok and sram_en are forced to 0.
- Latency: addr_ok at cycle N → data_ok at cycle N+1, exactly.
- Reset asserted mid-transaction: the response for the grant made in the reset cycle is dropped. No data_ok appears after reset deasserts.
- Simultaneous requests with streak = DATA_STREAK_MAX → inst granted, and streak becomes 0 next cycle.
- DATA_STREAK_MAX = 0 is illegal. Assert at elaboration.

## Structure
- Shared package core_mem_pkg holds:
  - the owner encoding (RESP_NONE = 2'd0, RESP_INST = 2'd1, RESP_DATA = 2'd2);
  - WSTRB_READ = 4'b0000.
- One sub-module, mem_port_arbiter_pick: the combinational grant chooser. Inputs are both reqs and the streak-at-limit flag. Outputs are one-hot grants.
- Owner register, streak counter, and SRAM muxing stay in the top of the block.

## Test plan
- Single fetch: inst_req = 1, addr 0x1c000000 for one cycle → inst_addr_ok same cycle; inst_data_ok next cycle with the SRAM word at 0x1c000000; sram_we = 0.
- Store then load:
  - data wstrb = 4'hf, addr 0x100, wdata 0xdeadbeef → data_data_ok at N+1.
  - Following load of 0x100 → data_rdata = 0xdeadbeef.
- Byte store: wstrb = 4'b0010, wdata 0x0000ab00 over 0x11223344 → subsequent read returns 0x1122ab44.
- Contention with DATA_STREAK_MAX = 4: both requesting continuously → grant sequence D,D,D,D,I,D,D,D,D,I. Every addr_ok is followed one cycle later by data_ok on the same port.
- Reset mid-operation: assert reset in the same cycle as a data grant → no data_data_ok afterwards; all outputs 0; streak restarts at 0.
- Idle: no requests for 10 cycles → sram_en = 0, all data_ok = 0, streak = 0.
